// File: rtl/u111_bus_arbiter.sv
// Local-bus arbiter between the 68040 and the PCI DMA bridge. The bus is parked on
// the CPU and lent to DMA only on request, with a tenure limit and a grant watchdog.
module u111_bus_arbiter #(
    parameter int unsigned MAX_TENURE    = 64,
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       BR_CPUn,
    input  logic       LOCKn,
    input  logic       BBn,
    input  logic       CYCLE_BUSY,
    input  logic       DMA_REQn,
    output logic       BG_CPUn,
    output logic       DMA_GNTn,
    output logic       DMA_PREEMPT,
    output logic [1:0] OWNER,
    output logic       GRANT_FAULT,
    output logic [2:0] STATE_DBG
);

    // Request/grant handshake: DMA_REQn low asks for the bus; DMA_GNTn low offers it;
    // the bridge accepts by pulling BBn low. Ownership ends when DMA_REQn goes high,
    // and the CPU is re-granted only after BBn is seen high again.
    typedef enum logic [2:0] {
        CPU_OWN    = 3'd0,
        HANDOFF    = 3'd1,
        GRANT_WAIT = 3'd2,
        DMA_OWN    = 3'd3,
        RETURN     = 3'd4
    } state_e;

    localparam logic [7:0] TENURE_LIM = 8'(MAX_TENURE - 1);
    localparam logic [7:0] GRANT_LIM  = 8'(GRANT_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] tenure_q, tenure_d;
    logic       bg_q, bg_d;
    logic       gnt_q, gnt_d;
    logic       pre_q, pre_d;
    logic [1:0] owner_q, owner_d;
    logic       fault_q, fault_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State and registered outputs.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= CPU_OWN;
            timer_q  <= 8'd0;
            tenure_q <= 8'd0;
            bg_q     <= 1'b0;
            gnt_q    <= 1'b1;
            pre_q    <= 1'b0;
            owner_q  <= 2'b00;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            tenure_q <= tenure_d;
            bg_q     <= bg_d;
            gnt_q    <= gnt_d;
            pre_q    <= pre_d;
            owner_q  <= owner_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tenure_d = tenure_q;
        case (state_q)
            CPU_OWN: begin
                if (!DMA_REQn && LOCKn && !CYCLE_BUSY) state_d = HANDOFF;
            end
            HANDOFF: begin
                if (DMA_REQn) begin
                    state_d = CPU_OWN;
                end else if (BBn && !CYCLE_BUSY) begin
                    state_d = GRANT_WAIT;
                    timer_d = 8'd0;
                end
            end
            GRANT_WAIT: begin
                timer_d = sat_inc(timer_q);
                if (!BBn) begin
                    state_d  = DMA_OWN;
                    tenure_d = 8'd0;
                end else if (DMA_REQn) begin
                    state_d = RETURN;
                end else if (timer_q >= GRANT_LIM) begin
                    state_d = RETURN;
                end
            end
            DMA_OWN: begin
                tenure_d = sat_inc(tenure_q);
                if (DMA_REQn) state_d = RETURN;
            end
            RETURN: begin
                if (BBn) state_d = CPU_OWN;
            end
            default: state_d = CPU_OWN;
        endcase
    end

    // Output next values, derived from the upcoming state so every output is a flop.
    always_comb begin
        bg_d    = (state_d != CPU_OWN);
        gnt_d   = !((state_d == GRANT_WAIT) || (state_d == DMA_OWN));
        owner_d = 2'b00;
        case (state_d)
            CPU_OWN:    owner_d = 2'b00;
            HANDOFF:    owner_d = 2'b01;
            GRANT_WAIT: owner_d = 2'b01;
            DMA_OWN:    owner_d = 2'b10;
            RETURN:     owner_d = 2'b11;
            default:    owner_d = 2'b00;
        endcase
        // Only the watchdog path out of GRANT_WAIT has BBn high and DMA_REQn still low.
        fault_d = (state_q == GRANT_WAIT) && (state_d == RETURN) && BBn && !DMA_REQn;
        pre_d   = (state_d == DMA_OWN) &&
                  (pre_q || ((state_q == DMA_OWN) && !BR_CPUn && (tenure_q >= TENURE_LIM)));
    end

    assign BG_CPUn     = bg_q;
    assign DMA_GNTn    = gnt_q;
    assign DMA_PREEMPT = pre_q;
    assign OWNER       = owner_q;
    assign GRANT_FAULT = fault_q;
    assign STATE_DBG   = state_q;

endmodule
